// File: rtl/fir_coeff_ctrl_if.sv
// Stream and FIR-core bundle for the coefficient sequencer.
// The master side feeds input beats and observes the FIR-facing outputs.
// The slave side (the sequencer) consumes beats and drives the FIR core.
interface fir_coeff_ctrl_if #(
    parameter int NUM_TAPS = 4,
    parameter int COEFF_W  = 8,
    parameter int DATA_W   = 8
) ();
    logic                          s_axis_fir_tvalid;
    logic [DATA_W-1:0]             s_axis_fir_tdata;
    logic [NUM_TAPS*COEFF_W-1:0]   coeff_flat;
    logic                          coeff_valid;
    logic                          fir_sample_en;
    logic [DATA_W-1:0]             fir_sample_data;
    logic                          fir_clear;

    modport master (
        output s_axis_fir_tvalid, s_axis_fir_tdata,
        input  coeff_flat, coeff_valid, fir_sample_en, fir_sample_data, fir_clear
    );

    modport slave (
        input  s_axis_fir_tvalid, s_axis_fir_tdata,
        output coeff_flat, coeff_valid, fir_sample_en, fir_sample_data, fir_clear
    );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient sequencer: a rising edge on s_set_coeffs starts a load of
// NUM_TAPS coefficient beats, then the FIR delay line is cleared for
// NUM_TAPS cycles, then input beats are forwarded to the FIR core as samples.
// A beat arriving in IDLE or FLUSH is counted as dropped, including one that
// coincides with a load-start edge (the edge wins, the beat is discarded).
module fir_coeff_ctrl #(
    parameter int NUM_TAPS = 4,
    parameter int COEFF_W  = 8,
    parameter int DATA_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_set_coeffs,
    fir_coeff_ctrl_if.slave      bus,
    output logic                 load_busy,
    output logic [7:0]           drop_cnt
);
    localparam int IDX_W = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_set_q;
    logic                 w_edge;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [IDX_W-1:0]     r_flush_cnt;
    logic [IDX_W-1:0]     w_flush_cnt_nxt;
    logic                 w_coeff_we;
    logic                 w_sample_take;
    logic                 w_drop;
    logic [COEFF_W-1:0]   r_coeff [NUM_TAPS];
    logic [NUM_TAPS*COEFF_W-1:0] w_coeff_flat;
    logic                 r_coeff_valid;
    logic                 r_sample_en;
    logic [DATA_W-1:0]    r_sample_data;
    logic                 r_fir_clear;
    logic                 r_load_busy;
    logic [7:0]           r_drop_cnt;

    assign w_edge = s_set_coeffs & ~r_set_q;

    // Next-state, tap index, flush counter and per-cycle strobes.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_flush_cnt_nxt = r_flush_cnt;
        w_coeff_we      = 1'b0;
        w_sample_take   = 1'b0;
        w_drop          = bus.s_axis_fir_tvalid &
                          ((r_state == ST_IDLE) | (r_state == ST_FLUSH));
        if (w_edge) begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_LOAD: begin
                    if (bus.s_axis_fir_tvalid) begin
                        w_coeff_we = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt     = ST_FLUSH;
                            w_idx_nxt       = '0;
                            w_flush_cnt_nxt = '0;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == LAST_IDX) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    w_sample_take = bus.s_axis_fir_tvalid;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register plus status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_set_q       <= 1'b0;
            r_idx         <= '0;
            r_flush_cnt   <= '0;
            r_coeff_valid <= 1'b0;
            r_fir_clear   <= 1'b0;
            r_load_busy   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_set_q       <= s_set_coeffs;
            r_idx         <= w_idx_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_coeff_valid <= (w_state_nxt == ST_RUN);
            r_fir_clear   <= (w_state_nxt == ST_FLUSH);
            r_load_busy   <= (w_state_nxt == ST_LOAD) | (w_state_nxt == ST_FLUSH);
        end
    end

    // Coefficient bank; never cleared by a new load, only overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_coeff[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (w_coeff_we && (r_idx == IDX_W'(k))) begin
                    r_coeff[k] <= COEFF_W'(bus.s_axis_fir_tdata);
                end
            end
        end
    end

    // Sample strobe/data to the FIR core and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample_en   <= 1'b0;
            r_sample_data <= '0;
            r_drop_cnt    <= 8'd0;
        end else begin
            r_sample_en <= w_sample_take;
            if (w_sample_take) begin
                r_sample_data <= bus.s_axis_fir_tdata;
            end
            if (w_drop && (r_drop_cnt != 8'd255)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Flatten the bank so tap k sits at [k*COEFF_W +: COEFF_W].
    always_comb begin
        w_coeff_flat = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_coeff_flat[k*COEFF_W +: COEFF_W] = r_coeff[k];
        end
    end

    assign bus.coeff_flat      = w_coeff_flat;
    assign bus.coeff_valid     = r_coeff_valid;
    assign bus.fir_sample_en   = r_sample_en;
    assign bus.fir_sample_data = r_sample_data;
    assign bus.fir_clear       = r_fir_clear;
    assign load_busy           = r_load_busy;
    assign drop_cnt            = r_drop_cnt;
endmodule
